// File: rtl/tick_div_pkg.sv
// Shared constants for the tick divider controller.
// FSM state encodings and state width.
package tick_div_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'b00;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'b01;
  localparam logic [STATE_W-1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/div_phase_counter.sv
// Reusable modulo-div phase counter.
// Ports: clk, reset, clr, en, div -> phase, wrap.
module div_phase_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] phase,
  output logic             wrap
);

  // div of 0 or 1 wraps every cycle; >= guards a
  // phase left beyond a newly shortened divisor.
  assign wrap = en
    & ((div <= WIDTH'(1))
    | (phase >= div - WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= wrap ? '0 : phase + WIDTH'(1);
    end
  end

endmodule

// File: rtl/tick_divider_ctrl.sv
// Divide-by-N tick controller with burst length.
// Ports: cfg_valid/ready/div/count, stop -> tick,
// busy, done, state, phase.
module tick_divider_ctrl
  import tick_div_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_div,
  input  logic [CNT_W-1:0]   cfg_count,
  input  logic               stop,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] state,
  output logic [WIDTH-1:0]   phase
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [WIDTH-1:0]   div_r;
  logic [CNT_W-1:0]   left_r;
  logic               hs;
  logic               in_run;
  logic               tick_i;
  logic               last;
  logic               wrap_unused;

  assign in_run = (state_q == ST_RUN);
  assign hs     = cfg_valid
                & (state_q == ST_IDLE);
  assign tick_i = in_run
                & (phase == '0);
  // left_r == 0 means free-run: never last.
  assign last   = tick_i
                & (left_r == CNT_W'(1));

  // Held clear outside RUN so each burst
  // starts its first period at phase 0.
  div_phase_counter #(
    .WIDTH (WIDTH)
  ) u_phase (
    .clk   (clk),
    .reset (reset),
    .clr   (!in_run),
    .en    (in_run),
    .div   (div_r),
    .phase (phase),
    .wrap  (wrap_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_r  <= WIDTH'(1);
      left_r <= '0;
    end else if (hs) begin
      div_r  <= (cfg_div == '0)
              ? WIDTH'(1) : cfg_div;
      left_r <= cfg_count;
    end else if (tick_i
             && left_r != '0) begin
      left_r <= left_r - CNT_W'(1);
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    unique case (1'b1)
      (state_q == ST_IDLE):
        state_d = hs ? ST_RUN : ST_IDLE;
      (state_q == ST_RUN):
        state_d = (last || stop)
                ? ST_DONE : ST_RUN;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    tick      = tick_i;
    state     = state_q;
  end

endmodule

// File: tb/tb_tick_divider_ctrl.sv
// Directed bench for tick_divider_ctrl.
// Per-cycle vector table plus corner sequences.
module tb_tick_divider_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_div;
  logic [7:0] cfg_count;
  logic       stop;
  logic       tick;
  logic       busy;
  logic       done;
  logic [1:0] state;
  logic [7:0] phase;

  tick_divider_ctrl #(
    .WIDTH (8),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_count (cfg_count),
    .stop      (stop),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .state     (state),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  localparam int K_IDLE = 0;
  localparam int K_TICK = 1;
  localparam int K_RUN  = 2;
  localparam int K_DONE = 3;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] c;
    logic       s;
    logic       t;
    logic       dn;
    logic       rdy;
    logic       bsy;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[$];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(string n, int act,
                     int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d want %0d",
                  n, act, exp);
  endtask

  task automatic add(bit v, int d, int c,
                     bit s, int k);
    vec_t e;
    e.v = v;
    e.d = d[7:0];
    e.c = c[7:0];
    e.s = s;
    case (k)
      K_IDLE: begin
        e.t = 0; e.dn = 0; e.rdy = 1;
        e.bsy = 0; e.st = 2'b00;
      end
      K_TICK: begin
        e.t = 1; e.dn = 0; e.rdy = 0;
        e.bsy = 1; e.st = 2'b01;
      end
      K_RUN: begin
        e.t = 0; e.dn = 0; e.rdy = 0;
        e.bsy = 1; e.st = 2'b01;
      end
      default: begin
        e.t = 0; e.dn = 1; e.rdy = 0;
        e.bsy = 1; e.st = 2'b10;
      end
    endcase
    tbl.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    cfg_valid = 0;
    cfg_div   = 0;
    cfg_count = 0;
    stop      = 0;
  endtask

  task automatic hs(int d, int c);
    cfg_valid = 1;
    cfg_div   = d[7:0];
    cfg_count = c[7:0];
    cyc();
    idle_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int ticks;
    int first;
    int second;
    int done_at;
    int ph100;
    int n;
    int dn_cnt;
    int tk_cnt;

    reset = 1;
    idle_in();
    @(negedge clk);
    cyc();
    reset = 0;
    chk("rst_tick", int'(tick), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    chk("rst_state", int'(state), 0);
    chk("rst_phase", int'(phase), 0);

    // stop toggling in IDLE is ignored
    add(0, 0, 0, 1, K_IDLE);
    add(0, 0, 0, 0, K_IDLE);
    add(0, 0, 0, 1, K_IDLE);
    // div 3, count 4; config during RUN ignored
    add(1, 3, 4, 0, K_IDLE);
    for (int i = 1; i <= 10; i++)
      add((i == 2 || i == 5), 1, 1, 0,
          ((i - 1) % 3 == 0) ? K_TICK : K_RUN);
    add(0, 0, 0, 0, K_DONE);
    add(0, 0, 0, 0, K_IDLE);
    // div 4 free-run, stop on 3rd tick
    add(1, 4, 0, 0, K_IDLE);
    for (int i = 1; i <= 9; i++)
      add(0, 0, 0, (i == 9),
          ((i - 1) % 4 == 0) ? K_TICK : K_RUN);
    add(0, 0, 0, 0, K_DONE);
    add(0, 0, 0, 0, K_IDLE);
    // stop on a non-tick cycle
    add(1, 4, 0, 0, K_IDLE);
    add(0, 0, 0, 0, K_TICK);
    add(0, 0, 0, 1, K_RUN);
    add(0, 0, 0, 0, K_DONE);
    add(0, 0, 0, 0, K_IDLE);
    // stop coincident with last tick
    add(1, 2, 2, 0, K_IDLE);
    add(0, 0, 0, 0, K_TICK);
    add(0, 0, 0, 0, K_RUN);
    add(0, 0, 0, 1, K_TICK);
    add(0, 0, 0, 0, K_DONE);
    add(0, 0, 0, 0, K_IDLE);
    add(0, 0, 0, 0, K_IDLE);

    foreach (tbl[i]) begin
      cfg_valid = tbl[i].v;
      cfg_div   = tbl[i].d;
      cfg_count = tbl[i].c;
      stop      = tbl[i].s;
      chk($sformatf("v%0d_tick", i),
          int'(tick), int'(tbl[i].t));
      chk($sformatf("v%0d_done", i),
          int'(done), int'(tbl[i].dn));
      chk($sformatf("v%0d_ready", i),
          int'(cfg_ready), int'(tbl[i].rdy));
      chk($sformatf("v%0d_busy", i),
          int'(busy), int'(tbl[i].bsy));
      chk($sformatf("v%0d_state", i),
          int'(state), int'(tbl[i].st));
      cyc();
    end
    idle_in();

    // div 0 and div 1: five back-to-back ticks
    for (int d = 0; d <= 1; d++) begin
      hs(d, 5);
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("d%0d_tick%0d", d, k),
            int'(tick), 1);
        cyc();
      end
      chk($sformatf("d%0d_done", d),
          int'(done), 1);
      chk($sformatf("d%0d_notick", d),
          int'(tick), 0);
      cyc();
      chk($sformatf("d%0d_ready", d),
          int'(cfg_ready), 1);
    end

    // div 255, count 2
    hs(255, 2);
    ticks   = 0;
    first   = -1;
    second  = -1;
    done_at = -1;
    ph100   = -1;
    n       = 0;
    while (n < 700 && done_at < 0) begin
      if (tick) begin
        ticks++;
        if (first < 0) first = n;
        else second = n;
      end
      if (n == 100) ph100 = int'(phase);
      if (done) done_at = n;
      cyc();
      n++;
    end
    chk("d255_ticks", ticks, 2);
    chk("d255_first", first, 0);
    chk("d255_second", second, 255);
    chk("d255_done", done_at, 256);
    chk("d255_phase100", ph100, 100);
    chk("d255_ready", int'(cfg_ready), 1);

    // reset mid-burst after 3rd tick
    hs(5, 10);
    ticks  = 0;
    dn_cnt = 0;
    n      = 0;
    while (n < 100 && ticks < 3) begin
      if (tick) ticks++;
      if (done) dn_cnt++;
      cyc();
      n++;
    end
    chk("mid_ticks", ticks, 3);
    chk("mid_nodone", dn_cnt, 0);
    reset = 1;
    cyc();
    reset = 0;
    chk("mid_state", int'(state), 0);
    chk("mid_phase", int'(phase), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_ready", int'(cfg_ready), 1);
    dn_cnt = 0;
    tk_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) dn_cnt++;
      if (tick) tk_cnt++;
      cyc();
    end
    chk("post_rst_done", dn_cnt, 0);
    chk("post_rst_tick", tk_cnt, 0);
    hs(2, 1);
    chk("new_tick", int'(tick), 1);
    cyc();
    chk("new_done", int'(done), 1);
    chk("new_notick", int'(tick), 0);
    cyc();
    chk("new_ready", int'(cfg_ready), 1);

    $display("%0d/%0d checks passed",
             passed, total);
    $finish;
  end

endmodule

// File: doc/tick_divider_ctrl.md
# tick_divider_ctrl

Programmable divide-by-N tick controller. It accepts a divisor and a burst length over a valid/ready configuration handshake, then emits single-cycle ticks every N cycles for the requested number of ticks or until stopped. It uses a Moore state machine with tick and done decoded from registered state. It sits between software-visible configuration and any block that needs a periodic enable: UART baud, sampling strobes, LED blinkers.

## Interface
- WIDTH, 8, divisor and phase counter width
- CNT_W, 8, burst tick count width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  high only in IDLE; handshake = cfg_valid & cfg_ready
- cfg_div  in  WIDTH  divisor N; 0 treated as 1
- cfg_count  in  CNT_W  ticks to emit; 0 = free-run until stop
- stop  in  1  abort request; honoured only in RUN
- tick  out  1  one-cycle enable, Moore: state==RUN & phase==0
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, state==DONE
- state  out  2  debug: current state encoding
- phase  out  WIDTH  debug: current phase counter

## Operation
- States: IDLE=2'b00, RUN=2'b01, DONE=2'b10; 2'b11 illegal → next state IDLE.
- IDLE: cfg_ready=1. On handshake, latch div_r = max(cfg_div,1) and left_r = cfg_count, clear phase, go to RUN. stop is ignored.
- RUN, phase: increments each cycle; wraps to 0 when phase == div_r-1. With div_r=1, phase stays 0 and tick is high every cycle.
- RUN, ticks left: on each tick cycle with left_r≠0, left_r decrements.
- RUN, exit: go to DONE when (tick & left_r==1) | stop. Otherwise stay in RUN. With left_r==0 (free-run), only stop exits.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- cfg_valid outside IDLE is ignored; no queueing; cfg_div/cfg_count sampled only at handshake.
- stop coincident with a tick: that tick is still emitted (Moore); next state DONE.
- stop coincident with last tick: single transition to DONE, no double done.
- Reset during any state: after the edge, state=IDLE, phase=0, div_r=1, left_r=0. Any burst in progress is lost with no done pulse.

## Timing
- Reset values: tick=0, busy=0, done=0, cfg_ready=1, state=2'b00, phase=0.
- Handshake at edge t → RUN from cycle t+1; first tick in cycle t+1 (latency 1).
- Tick k (k=1..K) occurs in cycle t+1+(k-1)·N.
- Burst K≥1: last tick at t+1+(K-1)·N; done at t+2+(K-1)·N; cfg_ready high at t+3+(K-1)·N.
- stop sampled high in a RUN cycle c → done in c+1, IDLE in c+2. No tick after cycle c.
- Back-to-back bursts: minimum 2 idle-side cycles (DONE, IDLE) between last tick and the next first tick.
- All outputs are decoded from registers only; no combinational input→output path. cfg_ready depends on state only.

## Structure
- Shared package tick_div_pkg:
  - localparams ST_IDLE, ST_RUN, ST_DONE
  - state width STATE_W=2
- Sub-module div_phase_counter (WIDTH): inputs clr, en, div; outputs phase and wrap. It is reusable by other divider blocks.
- Top holds the state register, div_r/left_r registers, next-state logic and output decode.

## Test plan
- Reset then idle: hold reset 2 cycles → tick=0, done=0, busy=0, cfg_ready=1, state=00; cfg_valid with stop toggling changes nothing until handshake.
- Divide-by-3 burst: cfg_div=3, cfg_count=4 handshake at t → ticks at t+1,t+4,t+7,t+10; done at t+11; cfg_ready at t+12; exactly 4 ticks.
- Edge divisors: cfg_div=0 and cfg_div=1, cfg_count=5 → tick high 5 consecutive cycles, then done. cfg_div=255, cfg_count=2 → ticks 255 cycles apart.
- Free-run and stop: cfg_div=4, cfg_count=0 → periodic ticks indefinitely. stop asserted on a tick cycle → that tick seen, done next cycle, no further ticks.
- Ignored config: cfg_valid with new values during RUN → no effect on period/count; cfg_ready stays 0 until IDLE.
- Reset mid-burst: cfg_div=5, cfg_count=10, reset after 3rd tick → IDLE next cycle, no done pulse, phase=0; new burst starts cleanly.
